bcd_event_counter: RTL and testbench
====================================

BCD_EVENT_COUNTER -- requirements
Module: bcd_event_counter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, is the number of consecutive clk cycles a synchronized button level must persist before it is accepted (10 ms at 50 MHz).
REQ-002 clk  input  1  single system clock; all state SHALL change only on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 btn_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk, bouncing.
REQ-005 up_dn  input  1  count direction: 1 = increment, 0 = decrement; sampled on the step cycle.
REQ-006 load  input  1  synchronous load strobe, level-sampled each cycle.
REQ-007 load_val  input  12  three BCD digits {hundreds, tens, ones}, 4 bits each, taken from switches.
REQ-008 digit0, digit1, digit2  output  4 each  registered BCD ones, tens, hundreds; they feed the downstream 7-segment digit decoders.
REQ-009 step  output  1  one-cycle pulse, high in the cycle after an accepted press changes the count.
REQ-010 wrap  output  1  one-cycle pulse, coincident with step, when the count wraps 999->000 or 000->999.

Function
REQ-011 btn_n SHALL pass through a two-flop synchronizer before any other use; sync latency 2 cycles.
REQ-012 The debouncer SHALL hold a stable level (reset value 1 = released) and a counter; the counter clears whenever the synchronized level equals the stable level.
REQ-013 When the synchronized level has differed from the stable level for DEBOUNCE_CYCLES consecutive cycles, the stable level SHALL toggle and the counter SHALL clear.
REQ-014 A single-cycle glitch, or any bounce shorter than DEBOUNCE_CYCLES, SHALL NOT change the stable level.
REQ-015 An accepted press SHALL be the stable level transitioning 1->0; a release (0->1) generates no event.
REQ-016 On an accepted press with load low: up_dn=1 increments the 3-digit BCD count, up_dn=0 decrements it; digits update on the next clock edge, with step high for that cycle.
REQ-017 BCD arithmetic: each digit is confined to 0-9; increment carries from a digit at 9 (which becomes 0); decrement borrows from a digit at 0 (which becomes 9).
REQ-018 Wrap boundaries: increment at 999 -> 000; decrement at 000 -> 999; wrap and step are both high for that one cycle.
REQ-019 load=1 SHALL copy load_val into the digits on the next edge; any load_val digit >9 is loaded as 9.
REQ-020 Load has priority: a press accepted in a load cycle is discarded, and step and wrap stay low.
REQ-021 Holding the button pressed SHALL produce exactly one event; a new event requires a release followed by a press, each debounced.
REQ-022 step and wrap SHALL be 0 in every cycle other than those specified in REQ-016 and REQ-018.

Reset
REQ-023 While reset is high, on every clk edge: digits = 0, step = wrap = 0, synchronizer flops = 1, stable level = 1, debounce counter = 0.
REQ-024 Reset asserted mid-debounce or mid-press SHALL discard the pending transition; a button still held after reset releases yields no event until it is released and pressed again.
REQ-025 Reset SHALL take priority over load and over any press.

Structure
REQ-026 A shared package SHALL hold the BCD digit width (4), the max BCD digit value (9), and the digit count (3).
REQ-027 One sub-module, bcd_digit, SHALL implement a single mod-10 up/down digit with load, enable, carry/borrow in, and carry/borrow out; it is instantiated three times in a ripple chain.
REQ-028 The debouncer counter width SHALL be $clog2(DEBOUNCE_CYCLES+1); the debouncer stays inline in bcd_event_counter.

Verification (DEBOUNCE_CYCLES=4 in simulation)
REQ-029 Reset; hold btn_n=0 for 10 cycles with up_dn=1 -> digits 0,0,1 (d2,d1,d0); step high exactly once, 7 cycles after the falling edge (2 sync + 4 debounce + 1 register).
REQ-030 Toggle btn_n 0/1 every 2 cycles for 20 cycles, then hold at 1 -> digits unchanged; step never asserted.
REQ-031 load_val=12'h999, pulse load, then one press with up_dn=1 -> digits 0,0,0, step=1 and wrap=1 in the same cycle.
REQ-032 Reset, then one press with up_dn=0 -> digits 9,9,9 and wrap=1; load_val=12'h0A0 then load -> digits 0,9,0.
REQ-033 Hold load=1 while a debounced press completes -> digits = load_val, step=0; assert reset 2 cycles into a second press -> digits 0,0,0 and no step while btn_n is held low.

Source files
------------

// File: rtl/bcd_event_counter_pkg.sv
// Shared BCD constants and types for the debounced three-digit event counter.
package bcd_event_counter_pkg;

    localparam int unsigned DigitW    = 4;
    localparam int unsigned DigitMax  = 9;
    localparam int unsigned NumDigits = 3;

    typedef logic [DigitW-1:0] bcd_t;

    localparam bcd_t BcdMax = bcd_t'(DigitMax);

    // Switch inputs can carry A-F; those saturate to 9 rather than wrap.
    function automatic bcd_t bcd_clamp(input bcd_t v);
        return (v > BcdMax) ? BcdMax : v;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One mod-10 up/down BCD digit with load, enable and a carry/borrow ripple link.
module bcd_digit
    import bcd_event_counter_pkg::*;
(
    input  logic clk_i,
    input  logic reset_i,
    input  logic load_i,
    input  bcd_t load_val_i,
    input  logic en_i,
    input  logic up_i,
    input  logic cin_i,
    output bcd_t q_o,
    output logic cout_o
);

    bcd_t q_q, q_d;

    // Carry/borrow out is combinational so a whole chain resolves in one cycle.
    assign cout_o = cin_i & (up_i ? (q_q == BcdMax) : (q_q == '0));
    assign q_o    = q_q;

    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = bcd_clamp(load_val_i);
        end else if (en_i && cin_i) begin
            if (up_i) begin
                q_d = (q_q == BcdMax) ? '0 : q_q + bcd_t'(1);
            end else begin
                q_d = (q_q == '0) ? BcdMax : q_q - bcd_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/bcd_event_counter.sv
// Debounced pushbutton driving a three-digit BCD up/down counter with load.
module bcd_event_counter
    import bcd_event_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_n,
    input  logic                          up_dn,
    input  logic                          load,
    input  logic [NumDigits*DigitW-1:0]   load_val,
    output logic [DigitW-1:0]             digit0,
    output logic [DigitW-1:0]             digit1,
    output logic [DigitW-1:0]             digit2,
    output logic                          step,
    output logic                          wrap
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]      sync_q;
    logic [1:0]      fill_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            armed_q;
    logic            press_q;
    logic            step_q;
    logic            wrap_q;
    logic            toggle;
    logic            btn_s;
    logic            advance;

    logic [NumDigits:0] carry;
    bcd_t               dig [NumDigits];

    assign btn_s = sync_q[1];

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        toggle   = 1'b0;
        if (btn_s == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
            toggle   = 1'b1;
            stable_d = ~stable_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    assign advance  = press_q & ~load;
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < NumDigits; i++) begin : g_digit
        bcd_digit u_digit (
            .clk_i      (clk),
            .reset_i    (reset),
            .load_i     (load),
            .load_val_i (load_val[i*DigitW +: DigitW]),
            .en_i       (advance),
            .up_i       (up_dn),
            .cin_i      (carry[i]),
            .q_o        (dig[i]),
            .cout_o     (carry[i+1])
        );
    end

    // A press is only honoured once a released level has been seen after reset;
    // fill_q masks the synchronizer's reset value so a held button cannot arm it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= 2'b11;
            fill_q   <= 2'b00;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            press_q  <= 1'b0;
            step_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_n};
            fill_q   <= {fill_q[0], 1'b1};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_q | (fill_q[1] & btn_s & stable_q);
            press_q  <= toggle & stable_q & armed_q;
            step_q   <= advance;
            wrap_q   <= advance & carry[NumDigits];
        end
    end

    assign digit0 = dig[0];
    assign digit1 = dig[1];
    assign digit2 = dig[2];
    assign step   = step_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench: presses push expected step events; a monitor pops them on each step pulse.
module tb_bcd_event_counter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        btn_n = 1'b1;
    logic        up_dn = 1'b1;
    logic        load = 1'b0;
    logic [11:0] load_val = '0;
    logic [3:0]  digit0, digit1, digit2;
    logic        step, wrap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model = 0;

    typedef struct {
        int          cyc;
        logic [11:0] dig;
        logic        wrap;
    } exp_t;

    exp_t sb[$];

    bcd_event_counter #(.DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_n    (btn_n),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .digit0   (digit0),
        .digit1   (digit1),
        .digit2   (digit2),
        .step     (step),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int clamp_val(input logic [11:0] lv);
        logic [3:0] h, t, o;
        h = (lv[11:8] > 4'd9) ? 4'd9 : lv[11:8];
        t = (lv[7:4]  > 4'd9) ? 4'd9 : lv[7:4];
        o = (lv[3:0]  > 4'd9) ? 4'd9 : lv[3:0];
        return int'(h) * 100 + int'(t) * 10 + int'(o);
    endfunction

    // Monitor: every step pulse must match the oldest expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && wrap && !step) begin
            errors++;
            $display("FAIL wrap_without_step at cycle %0d: wrap=%b step=%b, required wrap=0", cyc,
                     wrap, step);
        end
        if (step) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step at cycle %0d: digits=%h step=1, required step=0",
                         cyc, {digit2, digit1, digit0});
            end else begin
                e = sb.pop_front();
                if ({digit2, digit1, digit0} !== e.dig || wrap !== e.wrap || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL step_event: got digits=%h wrap=%b cycle=%0d, required digits=%h wrap=%b cycle=%0d",
                             {digit2, digit1, digit0}, wrap, cyc, e.dig, e.wrap, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_digits(input string name, input logic [11:0] exp_dig);
        checks++;
        if ({digit2, digit1, digit0} !== exp_dig || step !== 1'b0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL %s: got digits=%h step=%b wrap=%b, required digits=%h step=0 wrap=0",
                     name, {digit2, digit1, digit0}, step, wrap, exp_dig);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        model = 0;
        check_digits("reset_state", 12'h000);
        tick(5);
    endtask

    // Clean press: low for 10 cycles, then released for 10.
    task automatic press(input logic up, input logic expect_event);
        exp_t e;
        int   nxt;
        up_dn = up;
        btn_n = 1'b0;
        if (expect_event) begin
            nxt    = up ? (model + 1) % 1000 : (model + 999) % 1000;
            e.cyc  = cyc + 7;
            e.dig  = to_bcd(nxt);
            e.wrap = up ? (model == 999) : (model == 0);
            sb.push_back(e);
            model = nxt;
        end
        tick(10);
        btn_n = 1'b1;
        tick(10);
    endtask

    task automatic do_load(input logic [11:0] lv);
        load_val = lv;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        model = clamp_val(lv);
        tick(1);
    endtask

    initial begin
        do_reset();

        // Single held press counts once, step 7 cycles after the falling edge.
        press(1'b1, 1'b1);
        check_digits("first_press", 12'h001);
        press(1'b1, 1'b1);
        press(1'b0, 1'b1);
        check_digits("up_up_down", 12'h001);

        // Bounce with 2-cycle phases never debounces.
        for (int i = 0; i < 10; i++) begin
            btn_n = ~btn_n;
            tick(2);
        end
        btn_n = 1'b1;
        tick(10);
        check_digits("bounce_ignored", 12'h001);

        // Carry ripple through tens and hundreds.
        do_load(12'h199);
        check_digits("load_199", 12'h199);
        press(1'b1, 1'b1);
        check_digits("carry_200", 12'h200);
        press(1'b0, 1'b1);
        check_digits("borrow_199", 12'h199);

        // 999 -> 000 wrap.
        do_load(12'h999);
        check_digits("load_999", 12'h999);
        press(1'b1, 1'b1);
        check_digits("wrap_up", 12'h000);

        // 000 -> 999 wrap right after reset, then clamped load.
        do_reset();
        press(1'b0, 1'b1);
        check_digits("wrap_down", 12'h999);
        do_load(12'h0A0);
        check_digits("load_clamp", 12'h090);
        do_load(12'hFBC);
        check_digits("load_clamp_all", 12'h999);

        // Load held through a full press: press is discarded.
        load_val = 12'h456;
        load = 1'b1;
        press(1'b1, 1'b0);
        load = 1'b0;
        model = 456;
        tick(1);
        check_digits("load_priority", 12'h456);

        // Reset two cycles into a press; held button must not count.
        btn_n = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        model = 0;
        tick(14);
        check_digits("reset_mid_press", 12'h000);
        btn_n = 1'b1;
        tick(10);
        check_digits("release_after_reset", 12'h000);
        press(1'b1, 1'b1);
        check_digits("press_after_rearm", 12'h001);

        // Every expected event must have been observed.
        for (int i = 0; i < 50 && sb.size() != 0; i++) tick(1);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_steps: %0d events outstanding, required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
